// File: rtl/herm_extract_stream.sv
// Purpose: keeps FFT bins [FIRST_SC, FIRST_SC+ACTIVE_SC-1] of every symbol, discards DC/unused/mirror bins, and tags the last kept bin of each frame.
// Latency: a kept bin accepted into an empty FIFO is presented on m_valid/m_data one cycle later; frame_done pulses the cycle after the frame's last input bin.
// Backpressure: s_ready drops when the output FIFO holds FIFO_DEPTH words, for every bin. Optional macro HERM_MIRROR_CHECK_EN adds the herm_err Hermitian mirror check.
module herm_extract_stream #(
    parameter int DATA_W     = 16,
    parameter int FFT_N      = 64,
    parameter int FIRST_SC   = 1,
    parameter int ACTIVE_SC  = 28,
    parameter int SYM_NUM    = 8,
    parameter int FIFO_DEPTH = 256
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            tx_done,
    input  logic [DATA_W-1:0]               s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    output logic [DATA_W-1:0]               m_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic                            m_last,
    output logic                            frame_done,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
`ifdef HERM_MIRROR_CHECK_EN
    ,
    output logic                            herm_err
`endif
);

    localparam int BIN_W = (FFT_N > 1) ? $clog2(FFT_N) : 1;
    localparam int SYM_W = (SYM_NUM > 1) ? $clog2(SYM_NUM) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [BIN_W-1:0] BIN_MAX  = BIN_W'(FFT_N - 1);
    localparam logic [BIN_W-1:0] KEEP_LO  = BIN_W'(FIRST_SC);
    localparam logic [BIN_W-1:0] KEEP_HI  = BIN_W'(FIRST_SC + ACTIVE_SC - 1);
    localparam logic [SYM_W-1:0] SYM_MAX  = SYM_W'(SYM_NUM - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    // Kept band must sit strictly inside the lower half so its mirror never overlaps it.
    if (FIRST_SC < 1 || FIRST_SC + ACTIVE_SC > FFT_N / 2) begin : g_bad_params
        $fatal(1, "herm_extract_stream: kept band must satisfy FIRST_SC>=1 and FIRST_SC+ACTIVE_SC<=FFT_N/2");
    end

    logic [BIN_W-1:0] bin_cnt;
    logic [SYM_W-1:0] sym_cnt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [DATA_W:0]  fifo_mem [0:FIFO_DEPTH-1];
    logic [DATA_W:0]  rd_word;
    logic [LVL_W-1:0] level_nxt;

    logic in_fire;
    logic out_fire;
    logic keep_bin;
    logic bin_last;
    logic sym_last;
    logic last_tag;
    logic push;
    logic pop;

    assign in_fire  = s_valid & s_ready;
    assign out_fire = m_valid & m_ready;
    assign keep_bin = (bin_cnt >= KEEP_LO) && (bin_cnt <= KEEP_HI);
    assign bin_last = (bin_cnt == BIN_MAX);
    assign sym_last = (sym_cnt == SYM_MAX);
    assign last_tag = sym_last && (bin_cnt == KEEP_HI);

    // A flush cancels both the push and the pop of its own cycle.
    assign push = in_fire & keep_bin & ~tx_done;
    assign pop  = out_fire & ~tx_done;

    assign level_nxt = fifo_level + LVL_W'(push) - LVL_W'(pop);

    // Output side reads the head word directly; outputs are zeroed while nothing is queued.
    assign rd_word = fifo_mem[rd_ptr];
    assign m_valid = (fifo_level != '0);
    assign m_data  = m_valid ? rd_word[DATA_W-1:0] : '0;
    assign m_last  = m_valid & rd_word[DATA_W];

    // Storage array: no reset, only written on a kept-bin push.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {last_tag, s_data};
        end
    end

    // Bin/symbol position, FIFO pointers, occupancy, registered s_ready and frame_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_cnt    <= '0;
            sym_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            s_ready    <= 1'b0;
            frame_done <= 1'b0;
        end else if (tx_done) begin
            bin_cnt    <= '0;
            sym_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            s_ready    <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= in_fire & bin_last & sym_last;
            if (in_fire) begin
                if (bin_last) begin
                    bin_cnt <= '0;
                    sym_cnt <= sym_last ? '0 : sym_cnt + 1'b1;
                end else begin
                    bin_cnt <= bin_cnt + 1'b1;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_level <= level_nxt;
            // Derived from the next occupancy so a pop from full raises s_ready one cycle later.
            s_ready    <= (level_nxt != LVL_FULL);
        end
    end

`ifdef HERM_MIRROR_CHECK_EN
    localparam int HALF_W = DATA_W / 2;
    localparam logic [BIN_W-1:0] MIR_LO = BIN_W'(FFT_N - FIRST_SC - ACTIVE_SC + 1);
    localparam logic [BIN_W-1:0] MIR_HI = BIN_W'(FFT_N - FIRST_SC);

    logic [DATA_W-1:0] mir_mem [0:FFT_N-1];
    logic [DATA_W-1:0] mir_ref;
    logic [BIN_W-1:0]  mir_idx;
    logic              is_mirror;
    logic              mir_bad;

    // Mirror of bin b is FFT_N-b, which is just -b in BIN_W-bit arithmetic.
    assign mir_idx   = -bin_cnt;
    assign mir_ref   = mir_mem[mir_idx];
    assign is_mirror = (bin_cnt >= MIR_LO) && (bin_cnt <= MIR_HI);
    assign mir_bad   = (s_data[DATA_W-1:HALF_W] != mir_ref[DATA_W-1:HALF_W]) ||
                       (s_data[HALF_W-1:0] != HALF_W'(-mir_ref[HALF_W-1:0]));

    // Remember kept bins of the current symbol for comparison with their mirrors.
    always_ff @(posedge clk) begin
        if (in_fire && keep_bin) begin
            mir_mem[bin_cnt] <= s_data;
        end
    end

    // Sticky error flag, cleared only by reset or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            herm_err <= 1'b0;
        end else if (tx_done) begin
            herm_err <= 1'b0;
        end else if (in_fire && is_mirror && mir_bad) begin
            herm_err <= 1'b1;
        end
    end
`endif

endmodule
